fractal_scan_ctrl: RTL and testbench
====================================

// Module: fractal_scan_ctrl
// PURPOSE
//  Raster driver and result collector for the fractal evaluator. Issues x/y coordinates
//  frame by frame, tracks the evaluator's fixed pipeline latency, and converts the
//  returned iteration code to a binary index. Results leave on a valid/ready pixel
//  stream towards colour mapping and the frame buffer. Result FIFO plus credits give
//  full back-pressure with no pixel loss.
// PARAMETERS
//  H_RES     1280  pixels per line; x counts 0..H_RES-1
//  V_RES     720   lines per frame; y counts 0..V_RES-1
//  WS        16    coordinate word width (matches evaluator ws)
//  ITERWS    23    iteration code width (matches evaluator iterws)
//  IDXW      5     binary index width, >= clog2(ITERWS)
//  EVAL_LAT  0     evaluator latency in clocks (0 = combinational)
//  DEPTH     EVAL_LAT+2  result FIFO depth
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: begin a frame (ignored unless IDLE)
//  abort      in   1       1-cycle pulse: drop current frame, return to IDLE
//  busy       out  1       high from accepted start to frame_done/abort
//  frame_done out  1       1-cycle pulse when last pixel of frame is accepted
//  x, y       out  WS      coordinate to evaluator
//  iter_cnt   in   ITERWS  evaluator result, EVAL_LAT clocks after x/y
//  pix_valid  out  1       pixel stream valid
//  pix_ready  in   1       pixel stream ready
//  pix_x,pix_y out WS      coordinate of the pixel being output
//  pix_iter   out  IDXW    binary escape index
//  code_err   out  1       sticky: malformed iter_cnt seen; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; x=y=0; FIFO empty; credits full.
//  FSM: IDLE -start-> RUN; RUN -last coordinate issued-> DRAIN;
//   DRAIN -FIFO empty and pipe empty-> IDLE with frame_done=1 on the cycle the last
//   pixel handshakes. abort in RUN/DRAIN -> IDLE next clock; flushes FIFO and in-flight
//   tags; no frame_done. abort in IDLE ignored. abort and start same cycle: abort wins.
//  Issue: in RUN, one coordinate per clock when (fifo_count + inflight) < DEPTH.
//   x increments; at H_RES-1 wraps to 0 and y increments; issuing (H_RES-1,V_RES-1)
//   ends RUN. x/y hold when not issuing.
//  Tag pipe: EVAL_LAT-deep shift of {valid,x,y}. Its output (or the issue itself when
//   EVAL_LAT=0) writes {x,y,index(iter_cnt)} into the FIFO the same clock.
//   Credits prevent overflow; a write to a full FIFO is an assertion failure.
//  Code: iter_cnt is a thermometer, ones from bit0 up to the escape bit.
//   pix_iter = (count of contiguous trailing ones) - 1; all ones = ITERWS-1 (never
//   escaped). iter_cnt==0 or non-contiguous ones: pix_iter = trailing ones - 1
//   (0 if bit0 clear), code_err set.
//  Output: pix_* = FIFO head; pix_valid = FIFO non-empty; pop on pix_valid&pix_ready.
//   Payload stable while valid&!ready. Simultaneous push and pop on a full FIFO is
//   legal; count unchanged.
//  Throughput: 1 pixel/clock with pix_ready held high. First pix_valid comes
//   EVAL_LAT+1 clocks after start.
//  Reset mid-frame: immediate asynchronous return to reset state.
// TESTING  (H_RES=4, V_RES=3, EVAL_LAT=2, ITERWS=8, behavioural evaluator model)
//  1 start, ready=1 -> 12 pixels (0,0),(1,0)..(3,2) in order, back-to-back from clk 3
//    after start; frame_done on the 12th accept; busy low the next clock.
//  2 iter_cnt 0x01 -> pix_iter 0; 0x07 -> 2; 0xFF -> 7; code_err stays 0.
//  3 iter_cnt 0x00 -> pix_iter 0, code_err=1; 0x05 -> pix_iter 0, code_err=1;
//    next start clears it.
//  4 ready=0 for 20 clocks mid-frame -> issue stalls after DEPTH=4 outstanding; no
//    loss or duplication; payload stable; sequence resumes intact.
//  5 abort at pixel 5 with FIFO non-empty -> pix_valid=0 next clock, no frame_done;
//    a new start yields a full clean 12-pixel frame from (0,0).
//  6 rst_n low 1 cycle mid-DRAIN -> all outputs 0 asynchronously; start after release
//    yields a normal frame.

Source files
------------

// File: rtl/fractal_scan_ctrl.sv
// Raster driver for the fractal evaluator: issues x/y, tags them through the evaluator latency, decodes results.
// Latency: first pixel EVAL_LAT+1 clocks after start, then 1 pixel/clock.
// Backpressure: issue is credit-limited by result FIFO occupancy plus in-flight tags, so no pixel is ever dropped.
module fractal_scan_ctrl #(
    parameter int H_RES    = 1280,
    parameter int V_RES    = 720,
    parameter int WS       = 16,
    parameter int ITERWS   = 23,
    parameter int IDXW     = 5,
    parameter int EVAL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              frame_done,
    output logic [WS-1:0]     x,
    output logic [WS-1:0]     y,
    input  logic [ITERWS-1:0] iter_cnt,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [WS-1:0]     pix_x,
    output logic [WS-1:0]     pix_y,
    output logic [IDXW-1:0]   pix_iter,
    output logic              code_err
);
    localparam int DEPTH = EVAL_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int TW    = $clog2(ITERWS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [WS-1:0]   x;
        logic [WS-1:0]   y;
        logic [IDXW-1:0] idx;
    } pix_t;

    state_t          state;
    pix_t            mem [DEPTH];
    pix_t            head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   inflight;
    logic            issue;
    logic            flush;
    logic            pop;
    logic            wr_vld;
    logic [WS-1:0]   wr_x;
    logic [WS-1:0]   wr_y;
    logic [IDXW-1:0] idx;
    logic            bad;
    logic [TW-1:0]   ones;
    logic            run;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign flush      = abort && (state != IDLE);
    assign issue      = (state == RUN) && !abort &&
                        (({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(DEPTH));
    assign pix_valid  = (fifo_cnt != '0);
    assign pop        = pix_valid && pix_ready;
    assign head       = mem[rd_ptr];
    assign pix_x      = head.x;
    assign pix_y      = head.y;
    assign pix_iter   = head.idx;
    // Last pixel: nothing left behind it in the FIFO or the tag pipe.
    assign frame_done = (state == DRAIN) && !abort && pop &&
                        (fifo_cnt == CW'(1)) && (inflight == '0);

    generate
        if (EVAL_LAT == 0) begin : g_comb
            assign wr_vld   = issue;
            assign wr_x     = x;
            assign wr_y     = y;
            assign inflight = '0;
        end else begin : g_pipe
            logic [EVAL_LAT-1:0] pv;
            logic [WS-1:0]       px [EVAL_LAT];
            logic [WS-1:0]       py [EVAL_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    for (int i = 0; i < EVAL_LAT; i++) begin
                        px[i] <= '0;
                        py[i] <= '0;
                    end
                end else if (flush) begin
                    pv <= '0;
                end else begin
                    pv[0] <= issue;
                    px[0] <= x;
                    py[0] <= y;
                    for (int i = 1; i < EVAL_LAT; i++) begin
                        pv[i] <= pv[i-1];
                        px[i] <= px[i-1];
                        py[i] <= py[i-1];
                    end
                end
            end

            assign wr_vld   = pv[EVAL_LAT-1];
            assign wr_x     = px[EVAL_LAT-1];
            assign wr_y     = py[EVAL_LAT-1];
            assign inflight = CW'($countones(pv));
        end
    endgenerate

    // Thermometer decode: any set bit above the trailing run of ones is malformed.
    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < ITERWS; i++) begin
            if (run && iter_cnt[i]) ones = ones + TW'(1);
            else                    run  = 1'b0;
        end
        idx = (ones == '0) ? '0 : IDXW'(ones - TW'(1));
        bad = (ones == '0) || ((iter_cnt >> ones) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= {wr_x, wr_y, idx};
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(wr_vld) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_vld && !flush && !pop && (fifo_cnt == CW'(DEPTH))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            x        <= '0;
            y        <= '0;
            code_err <= 1'b0;
        end else begin
            if (wr_vld && !flush && bad) code_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        code_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        x     <= '0;
                        y     <= '0;
                    end else if (issue) begin
                        if (x == WS'(H_RES - 1)) begin
                            x <= '0;
                            if (y == WS'(V_RES - 1)) begin
                                y     <= '0;
                                state <= DRAIN;
                            end else begin
                                y <= y + WS'(1);
                            end
                        end else begin
                            x <= x + WS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort || frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fractal_scan_ctrl.sv
module tb_fractal_scan_ctrl;
    localparam int H = 4, V = 3, WS = 16, IW = 8, XW = 5, LAT = 2, NPIX = H * V;

    logic clk = 1'b0;
    logic rst_n, start, abort, pix_ready;
    logic busy, frame_done, pix_valid, code_err;
    logic [WS-1:0] x, y, pix_x, pix_y;
    logic [IW-1:0] iter_cnt;
    logic [XW-1:0] pix_iter;

    fractal_scan_ctrl #(.H_RES(H), .V_RES(V), .WS(WS), .ITERWS(IW), .IDXW(XW), .EVAL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
        .frame_done(frame_done), .x(x), .y(y), .iter_cnt(iter_cnt),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_iter(pix_iter), .code_err(code_err));

    always #5 clk = ~clk;

    // Behavioural evaluator: code looked up by coordinate, delayed LAT clocks.
    logic [IW-1:0] code_tab [NPIX];
    logic [IW-1:0] d1, d2;
    always @(posedge clk) begin
        d1 <= code_tab[int'(y) * H + int'(x)];
        d2 <= d1;
    end
    assign iter_cnt = d2;

    function automatic int thermo_len(logic [IW-1:0] c);
        int t = 0;
        for (int i = 0; i < IW; i++) if (c[i] && t == i) t = i + 1;
        return t;
    endfunction
    function automatic int exp_idx(logic [IW-1:0] c);
        int t = thermo_len(c);
        return (t == 0) ? 0 : t - 1;
    endfunction
    function automatic bit exp_bad(logic [IW-1:0] c);
        int t = thermo_len(c);
        return (c == 0) || (int'(c) != ((1 << t) - 1));
    endfunction

    typedef struct { int px; int py; int idx; } pix_e;
    pix_e exp_q[$];
    int got_iter[$];
    int n_chk = 0, n_pass = 0;
    int acc_cnt = 0, fd_cnt = 0, first_acc = 0, last_acc = 0, cyc = 0;
    bit frame_bad;

    task automatic chk(string name, longint act, longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    bit prev_stall = 0, prev_abort = 0;
    logic [WS-1:0] prev_x, prev_y;
    logic [XW-1:0] prev_i;
    always @(negedge clk) begin
        pix_e e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && !prev_abort)
                chk("hold", {pix_valid, pix_x, pix_y, pix_iter}, {1'b1, prev_x, prev_y, prev_i});
            if (pix_valid && pix_ready) begin
                chk("pix_avail", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pix_x", pix_x, e.px);
                    chk("pix_y", pix_y, e.py);
                    chk("pix_iter", pix_iter, e.idx);
                    chk("frame_done", frame_done, int'(exp_q.size() == 0));
                end
                acc_cnt++;
                got_iter.push_back(int'(pix_iter));
                if (acc_cnt == 1) first_acc = cyc;
                last_acc = cyc;
            end else begin
                chk("no_done", frame_done, 0);
            end
            if (frame_done) fd_cnt++;
            prev_stall = pix_valid && !pix_ready;
            prev_abort = abort;
            prev_x = pix_x; prev_y = pix_y; prev_i = pix_iter;
        end
    end

    task automatic set_good();
        for (int p = 0; p < NPIX; p++) code_tab[p] = 8'((1 << ((p % 8) + 1)) - 1);
    endtask

    task automatic start_frame();
        exp_q.delete(); got_iter.delete();
        acc_cnt = 0; fd_cnt = 0; frame_bad = 0;
        for (int p = 0; p < NPIX; p++) begin
            exp_q.push_back('{p % H, p / H, exp_idx(code_tab[p])});
            if (exp_bad(code_tab[p])) frame_bad = 1;
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1;
        chk("busy_start", busy, 1);
        chk("err_clr", code_err, 0);
        repeat (2) @(negedge clk);
        #1 chk("lat_pre", pix_valid, 0);
        @(negedge clk);
        #1 chk("lat_first", pix_valid, 1);
    endtask

    task automatic wait_acc(int n);
        int i = 0;
        while (acc_cnt < n && i < 300) begin
            @(negedge clk); #1;
            i++;
        end
        chk("acc_timeout", int'(acc_cnt >= n), 1);
    endtask

    task automatic wait_done();
        int i = 0;
        while (fd_cnt == 0 && i < 300) begin
            @(negedge clk); #1;
            i++;
        end
        chk("done_timeout", int'(fd_cnt > 0), 1);
        @(negedge clk); #1;
        chk("busy_after", busy, 0);
        chk("acc_total", acc_cnt, NPIX);
        chk("fd_once", fd_cnt, 1);
        chk("code_err", code_err, int'(frame_bad));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        set_good();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_pix", {pix_x, pix_y, pix_iter}, 0);
        chk("rst_err", code_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain frame, back-to-back output
        pix_ready = 1'b1;
        start_frame();
        wait_done();
        chk("b2b", last_acc - first_acc, NPIX - 1);

        // 2: well-formed codes
        code_tab[0] = 8'h01; code_tab[1] = 8'h07; code_tab[2] = 8'hFF;
        @(posedge clk); #1;
        start_frame();
        wait_done();
        chk("iter_01", got_iter[0], 0);
        chk("iter_07", got_iter[1], 2);
        chk("iter_ff", got_iter[2], 7);

        // 3: malformed codes
        set_good();
        code_tab[3] = 8'h00; code_tab[4] = 8'h05;
        @(posedge clk); #1;
        start_frame();
        wait_done();
        chk("iter_00", got_iter[3], 0);
        chk("iter_05", got_iter[4], 0);
        chk("err_set", code_err, 1);

        // 4: long stall mid-frame; start must also clear code_err
        set_good();
        @(posedge clk); #1;
        start_frame();
        wait_acc(3);
        @(posedge clk); #1 pix_ready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_x", x, 3);
        chk("stall_y", y, 1);
        chk("stall_head", {pix_valid, pix_x, pix_y}, {1'b1, 16'd3, 16'd0});
        @(posedge clk); #1 pix_ready = 1'b1;
        wait_done();

        // 5: abort with FIFO non-empty, then clean frame
        @(posedge clk); #1;
        start_frame();
        wait_acc(5);
        @(posedge clk); #1 pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 chk("abort_pre_valid", pix_valid, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        chk("abort_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1 chk("abort_no_done", fd_cnt, 0);
        pix_ready = 1'b1;
        start_frame();
        wait_done();

        // 6: asynchronous reset during drain
        @(posedge clk); #1;
        start_frame();
        wait_acc(11);
        chk("drain_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_xy", {x, y}, 0);
        chk("arst_pix", {pix_x, pix_y, pix_iter}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        start_frame();
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
